// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding,
// default widths and the command map of the ALU it fronts.
package alu_arbiter_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CMD_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Command map of the external ALU; the arbiter passes commands through
  // untouched, these are here so requesters and models share one encoding.
  localparam logic [CMD_W_DEF-1:0] ALU_CMD_ADD = 2'b00;
  localparam logic [CMD_W_DEF-1:0] ALU_CMD_SUB = 2'b01;
  localparam logic [CMD_W_DEF-1:0] ALU_CMD_AND = 2'b10;
  localparam logic [CMD_W_DEF-1:0] ALU_CMD_OR  = 2'b11;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes, ALU connection and response channel.
// slave is the arbiter's view; master is the surrounding logic's view.
interface alu_arbiter_if #(
  parameter int WIDTH = alu_arbiter_pkg::WIDTH_DEF,
  parameter int CMD_W = alu_arbiter_pkg::CMD_W_DEF
);

  logic             req0_valid;
  logic             req0_ready;
  logic [CMD_W-1:0] req0_cmd;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [CMD_W-1:0] req1_cmd;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [CMD_W-1:0] alu_cmd;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;

  modport slave (
    input  req0_valid, req0_cmd, req0_a, req0_b,
    input  req1_valid, req1_cmd, req1_a, req1_b,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready,
    output alu_cmd, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0_valid, req0_cmd, req0_a, req0_b,
    output req1_valid, req1_cmd, req1_a, req1_b,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_cmd, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on contention
// the pointer decides. The pointer moves to the loser only when the caller
// reports that the grant was actually taken (upd_i).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic ptr_q, ptr_d;

  // Grant selection and pointer next-state
  always_comb begin
    gnt_id_o = 1'b0;
    gnt_o    = 2'b00;
    unique case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ptr_q;
      default: gnt_id_o = 1'b0;
    endcase
    if (req_i != 2'b00) begin
      gnt_o = gnt_id_o ? 2'b10 : 2'b01;
    end
    ptr_d = upd_i ? ~gnt_id_o : ptr_q;
  end

  // Priority pointer; requester 0 first out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Flow per operation: IDLE (accept) -> EXEC (drive ALU) -> RESP (hold
// result until the consumer takes it). Readys are only raised in IDLE, so
// a pending response back-pressures both requesters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CMD_W = CMD_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  alu_arbiter_if.slave   bus
);

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic       in_idle;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       hs;

  assign in_idle = (state_q == ST_IDLE);
  // A grant only exists when its requester is valid, so grant-in-IDLE is
  // exactly the valid&ready handshake.
  assign hs      = in_idle && (gnt != 2'b00);

  rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({bus.req1_valid, bus.req0_valid}),
    .upd_i    (hs),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign bus.req0_ready = in_idle && gnt[0];
  assign bus.req1_ready = in_idle && gnt[1];

  // Latched operands feed the ALU directly, so they are stable through EXEC
  // and simply hold their last value afterwards.
  assign bus.alu_cmd   = cmd_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

  // Next-state: FSM, operand latch and response capture
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          id_d    = gnt_id;
          cmd_d   = gnt_id ? bus.req1_cmd : bus.req0_cmd;
          a_d     = gnt_id ? bus.req1_a   : bus.req0_a;
          b_d     = gnt_id ? bus.req1_b   : bus.req0_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = bus.alu_out;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic. A
// transaction-level model decides grants and queues expected responses;
// a separate monitor pops and compares whenever a response is presented.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk;
  logic rst;

  alu_arbiter_if #(.WIDTH(4), .CMD_W(2)) bus ();

  alu_arbiter #(.WIDTH(4), .CMD_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The ALU that lives outside the arbiter
  always_comb begin
    bus.alu_out = 4'd0;
    case (bus.alu_cmd)
      ALU_CMD_ADD: bus.alu_out = bus.alu_a + bus.alu_b;
      ALU_CMD_SUB: bus.alu_out = bus.alu_a - bus.alu_b;
      ALU_CMD_AND: bus.alu_out = bus.alu_a & bus.alu_b;
      ALU_CMD_OR:  bus.alu_out = bus.alu_a | bus.alu_b;
      default:     bus.alu_out = 4'd0;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int ref_alu(input int cmd, input int a, input int b);
    int r;
    case (cmd)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      default: r = a | b;
    endcase
    return r & 15;
  endfunction

  typedef struct {
    int id;
    int data;
    int due;
  } exp_t;

  exp_t sbq[$];

  // Reference model: one operation in flight at a time; busy from accept
  // until the response is taken. Due = two sample points after accept.
  bit m_busy = 0;
  int m_ptr  = 0;
  int m_due  = 0;
  int m_cyc  = 0;

  always @(negedge clk) begin
    bit   g0, g1;
    int   gid;
    exp_t e;
    g0 = 0; g1 = 0; gid = 0;
    if (!m_busy) begin
      if (bus.req0_valid && !bus.req1_valid) begin g0 = 1; gid = 0; end
      else if (bus.req1_valid && !bus.req0_valid) begin g1 = 1; gid = 1; end
      else if (bus.req0_valid && bus.req1_valid) begin
        gid = m_ptr; g0 = (m_ptr == 0); g1 = (m_ptr == 1);
      end
    end
    chk("req0_ready", int'(bus.req0_ready), int'(g0));
    chk("req1_ready", int'(bus.req1_ready), int'(g1));
    chk("rsp_valid", int'(bus.rsp_valid), int'(m_busy && (m_cyc >= m_due)));
    if (rst) begin
      if (m_busy && (m_due > m_cyc)) void'(sbq.pop_back());
      m_busy = 0;
      m_ptr  = 0;
    end else if (g0 || g1) begin
      e.id   = gid;
      e.data = (gid == 0) ? ref_alu(int'(bus.req0_cmd), int'(bus.req0_a), int'(bus.req0_b))
                          : ref_alu(int'(bus.req1_cmd), int'(bus.req1_a), int'(bus.req1_b));
      e.due  = m_cyc + 2;
      sbq.push_back(e);
      m_ptr  = 1 - gid;
      m_busy = 1;
      m_due  = m_cyc + 2;
    end else if (m_busy && (m_cyc >= m_due) && bus.rsp_ready) begin
      m_busy = 0;
    end
    m_cyc++;
  end

  // Response monitor
  bit   mon_act = 0;
  int   mon_cyc = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!bus.rsp_valid) begin
      mon_act = 0;
    end else begin
      if (!mon_act) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected_qsize", sbq.size(), 1);
        end else begin
          cur = sbq.pop_front();
          mon_act = 1;
          chk("rsp_latency", mon_cyc, cur.due);
        end
      end
      if (mon_act) begin
        chk("rsp_id", int'(bus.rsp_id), cur.id);
        chk("rsp_data", int'(bus.rsp_data), cur.data);
        if (bus.rsp_ready) mon_act = 0;
      end
    end
    mon_cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set0(input bit v, input int c, input int a, input int b);
    bus.req0_valid = v; bus.req0_cmd = 2'(c); bus.req0_a = 4'(a); bus.req0_b = 4'(b);
  endtask

  task automatic set1(input bit v, input int c, input int a, input int b);
    bus.req1_valid = v; bus.req1_cmd = 2'(c); bus.req1_a = 4'(a); bus.req1_b = 4'(b);
  endtask

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_data", int'(bus.rsp_data), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_alu_cmd", int'(bus.alu_cmd), 0);
    chk("rst_alu_a", int'(bus.alu_a), 0);
    chk("rst_alu_b", int'(bus.alu_b), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // req0 alone: ADD 1+2
    bus.rsp_ready = 1'b1;
    set0(1, 0, 1, 2);
    tick(1);
    set0(0, 0, 0, 0);
    tick(3);

    // Contention: alternating grants, SUB wraps to 1011, AND gives 0
    set0(1, 1, 5, 10);
    set1(1, 2, 5, 10);
    tick(12);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    tick(3);

    // Back-pressure with req1 waiting
    bus.rsp_ready = 1'b0;
    set0(1, 0, 3, 4);
    tick(1);
    set0(0, 0, 0, 0);
    set1(1, 3, 9, 6);
    tick(6);
    bus.rsp_ready = 1'b1;
    tick(4);
    set1(0, 0, 0, 0);
    tick(3);

    // Reset during EXEC
    set0(1, 1, 7, 2);
    tick(1);
    set0(0, 0, 0, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("midrst_alu_a", int'(bus.alu_a), 0);
    tick(2);

    // req1 changes operand while req0 is served
    set0(1, 0, 1, 1);
    set1(1, 0, 3, 1);
    tick(1);
    set0(0, 0, 0, 0);
    set1(1, 0, 7, 1);
    tick(5);
    set1(0, 0, 0, 0);
    tick(2);

    // Idle, then contention to show the pointer held
    tick(10);
    set0(1, 3, 8, 1);
    set1(1, 2, 15, 6);
    tick(6);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    tick(3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set0($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
      set1($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end

    rst = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    tick(6);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
